axi4l_my_mst_wrapper: RTL and testbench

AXI4L_MY_MST_WRAPPER -- requirements
Module: axi4l_my_mst_wrapper

---
 rtl/axi4l_my_mst_wrapper_pkg.sv | 30 +++
 rtl/axi4l_my_mst_wrapper_if.sv | 56 +++++
 rtl/axi4l_slave_mem.sv | 96 +++++++++
 rtl/axi4l_my_mst_wrapper.sv | 165 ++++++++++++++++
 tb/tb_axi4l_my_mst_wrapper.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/axi4l_my_mst_wrapper_pkg.sv
// ---------------------------------------------------------------------------
// axi4l_my_mst_wrapper_pkg
// Shared definitions for the AXI4-Lite master wrapper and its private slave
// memory: bus widths, fixed AXI side-band values, response codes and the
// master FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package axi4l_my_mst_wrapper_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0]        PROT_DEFAULT = 3'b000;
    localparam logic [STRB_W-1:0] STRB_ALL     = {STRB_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } mstState_t;

endpackage

// File: rtl/axi4l_my_mst_wrapper_if.sv
// ---------------------------------------------------------------------------
// axi4l_my_mst_wrapper_if
// The private 32-bit AXI4-Lite bus joining the wrapper's master FSM to the
// slave memory. Carries the five AXI4-Lite channels (AW, W, B, AR, R).
// Modports:
//   master - drives AW/W/AR valid+payload, bready, rready
//   slave  - drives awready, wready, B channel, arready, R channel
// ---------------------------------------------------------------------------
interface axi4l_my_mst_wrapper_if;
    import axi4l_my_mst_wrapper_pkg::*;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4l_slave_mem.sv
// ---------------------------------------------------------------------------
// axi4l_slave_mem
// Small AXI4-Lite slave backed by a MEM_WORDS x 32-bit register array.
// Only the word index addr[log2(MEM_WORDS)+1:2] is decoded, so the memory
// aliases across the rest of the address space. Always answers OKAY.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, also clears the memory
//   s_axi - AXI4-Lite slave side of the private bus
// ---------------------------------------------------------------------------
module axi4l_slave_mem
    import axi4l_my_mst_wrapper_pkg::*;
#(
    parameter int MEM_WORDS = 16
) (
    input  logic clk,
    input  logic rst,
    axi4l_my_mst_wrapper_if.slave s_axi
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic              r_bvalid;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    logic [IDX_W-1:0]  w_wrIdx;
    logic [IDX_W-1:0]  w_rdIdx;
    logic              w_wrAccept;
    logic              w_rdAccept;
    logic              w_unusedBits;

    assign w_wrIdx = s_axi.awaddr[IDX_W+1:2];
    assign w_rdIdx = s_axi.araddr[IDX_W+1:2];

    // Address and data are taken in the same cycle, and only while no write
    // response is still outstanding, so B never has to queue.
    assign w_wrAccept = s_axi.awvalid & s_axi.wvalid & ~r_bvalid;
    assign w_rdAccept = s_axi.arvalid & ~r_rvalid;

    assign s_axi.awready = w_wrAccept;
    assign s_axi.wready  = w_wrAccept;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.arready = w_rdAccept;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = RESP_OKAY;

    // Aliased address bits and protection fields carry no meaning here.
    assign w_unusedBits = ^{s_axi.awaddr[ADDR_W-1:IDX_W+2], s_axi.awaddr[1:0],
                            s_axi.araddr[ADDR_W-1:IDX_W+2], s_axi.araddr[1:0],
                            s_axi.awprot, s_axi.arprot};

    // Write path: memory update with byte strobes, then hold bvalid until
    // the master takes the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_bvalid <= 1'b0;
        end else begin
            if (r_bvalid && s_axi.bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_wrAccept) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (s_axi.wstrb[b]) begin
                        r_mem[w_wrIdx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                    end
                end
                r_bvalid <= 1'b1;
            end
        end
    end

    // Read path: capture the addressed word on AR acceptance and hold it on
    // R until the master is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (r_rvalid && s_axi.rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_rdAccept) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_mem[w_rdIdx];
            end
        end
    end

endmodule

// File: rtl/axi4l_my_mst_wrapper.sv
// ---------------------------------------------------------------------------
// axi4l_my_mst_wrapper
// Single-transaction AXI4-Lite master driven by a txn pulse, talking over a
// private bus to an internal axi4l_slave_mem.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset (aborts any transaction)
//   txn    - one-cycle start pulse, honoured only when idle
//   rw     - 0 = write, 1 = read, sampled with txn
//   addr   - byte address, sampled with txn
//   wdata  - write data, sampled with txn
//   rdata  - data of the last completed read, held until the next one
//   rvalid - one-cycle pulse when rdata is updated
//   busy   - high while a transaction is in flight
// ---------------------------------------------------------------------------
module axi4l_my_mst_wrapper
    import axi4l_my_mst_wrapper_pkg::*;
#(
    parameter int MEM_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              txn,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);

    axi4l_my_mst_wrapper_if w_axi ();

    mstState_t         r_state;
    mstState_t         w_nextState;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_awDone;
    logic              r_wDone;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_accept;
    logic              w_awValid;
    logic              w_wValid;
    logic              w_bReady;
    logic              w_arValid;
    logic              w_rReady;
    logic              w_awHs;
    logic              w_wHs;
    logic              w_bHs;
    logic              w_arHs;
    logic              w_rHs;
    logic              w_unusedBits;

    axi4l_slave_mem #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .s_axi (w_axi)
    );

    assign w_accept = (r_state == ST_IDLE) && txn;

    // Channel valids/readies are pure functions of state and the per-channel
    // done flags, so each valid stays up until its own ready is seen.
    assign w_awValid = (r_state == ST_WRITE) && !r_awDone;
    assign w_wValid  = (r_state == ST_WRITE) && !r_wDone;
    assign w_bReady  = (r_state == ST_WRESP);
    assign w_arValid = (r_state == ST_RADDR);
    assign w_rReady  = (r_state == ST_RDATA);

    assign w_awHs = w_awValid & w_axi.awready;
    assign w_wHs  = w_wValid  & w_axi.wready;
    assign w_bHs  = w_bReady  & w_axi.bvalid;
    assign w_arHs = w_arValid & w_axi.arready;
    assign w_rHs  = w_rReady  & w_axi.rvalid;

    assign w_axi.awvalid = w_awValid;
    assign w_axi.awaddr  = r_addr;
    assign w_axi.awprot  = PROT_DEFAULT;
    assign w_axi.wvalid  = w_wValid;
    assign w_axi.wdata   = r_wdata;
    assign w_axi.wstrb   = STRB_ALL;
    assign w_axi.bready  = w_bReady;
    assign w_axi.arvalid = w_arValid;
    assign w_axi.araddr  = r_addr;
    assign w_axi.arprot  = PROT_DEFAULT;
    assign w_axi.rready  = w_rReady;

    // Error responses are deliberately not acted on, and the direction only
    // steers the IDLE decision, so its registered copy is informational.
    assign w_unusedBits = ^{r_rw, w_axi.bresp, w_axi.rresp};

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = (r_state != ST_IDLE);

    // Next-state logic. WRITE waits for both the AW and W handshakes, which
    // may land in the same cycle or in different ones.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (txn) begin
                    w_nextState = rw ? ST_RADDR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
                    w_nextState = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (w_bHs) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (w_arHs) begin
                    w_nextState = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (w_rHs) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register, captured request, per-channel done flags and the
    // user-facing read result. Done flags only live while in WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_awDone <= (w_nextState == ST_WRITE) && (r_awDone || w_awHs);
            r_wDone  <= (w_nextState == ST_WRITE) && (r_wDone || w_wHs);
            r_rvalid <= w_rHs;
            if (w_rHs) begin
                r_rdata <= w_axi.rdata;
            end
            if (w_accept) begin
                r_rw    <= rw;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_axi4l_my_mst_wrapper.sv
// ---------------------------------------------------------------------------
// tb_axi4l_my_mst_wrapper
// Self-checking bench for axi4l_my_mst_wrapper. A word-array model of the
// 16-word aliased memory plus the last read value predicts every result.
// ---------------------------------------------------------------------------
module tb_axi4l_my_mst_wrapper;

    localparam int WORDS = 16;

    logic        clk;
    logic        rst;
    logic        txn;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;

    int          checkCount;
    int          errCount;
    logic [31:0] modelMem [WORDS];
    logic [31:0] lastRead;

    axi4l_my_mst_wrapper #(
        .MEM_WORDS (WORDS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .txn    (txn),
        .rw     (rw),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so a stuck design still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int wordOf(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    function automatic void clearModel();
        for (int i = 0; i < WORDS; i++) modelMem[i] = '0;
        lastRead = '0;
    endfunction

    // Wait (bounded) for busy to drop; returns negedges waited.
    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 12) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Issue one txn pulse at a negedge, scramble the inputs afterwards, then
    // follow it to completion and compare against the model.
    task automatic applyStimulus(input logic isRead, input logic [31:0] a,
                                 input logic [31:0] d, input string tag);
        int cycles;
        int pulses;
        cycles = 0;
        pulses = 0;
        txn = 1'b1; rw = isRead; addr = a; wdata = d;
        @(negedge clk);
        txn = 1'b0; rw = 1'($urandom); addr = $urandom; wdata = $urandom;
        checkOutput({tag, "_busyHigh"}, 32'(busy), 32'd1);
        while (busy === 1'b1 && cycles < 12) begin
            if (rvalid === 1'b1) pulses++;
            @(negedge clk);
            cycles++;
        end
        if (rvalid === 1'b1) pulses++;
        if (isRead) lastRead = modelMem[wordOf(a)];
        else        modelMem[wordOf(a)] = d;
        checkOutput({tag, "_doneIn4"}, 32'((cycles <= 4) ? 1 : 0), 32'd1);
        checkOutput({tag, "_rdata"}, rdata, lastRead);
        @(negedge clk);
        if (rvalid === 1'b1) pulses++;
        checkOutput({tag, "_rvalidPulses"}, 32'(pulses), isRead ? 32'd1 : 32'd0);
        checkOutput({tag, "_rdataHeld"}, rdata, lastRead);
    endtask

    initial begin
        int cycles;
        int falls;
        logic prevBusy;
        logic [31:0] a;
        logic [31:0] d;
        logic isRd;

        checkCount = 0;
        errCount   = 0;
        clearModel();
        rst = 1'b1; txn = 1'b0; rw = 1'b0; addr = '0; wdata = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic write then read");
        applyStimulus(1'b0, 32'h44A0_0000, 32'h1234_5678, "wr0");
        applyStimulus(1'b1, 32'h44A0_0000, 32'h0, "rd0");

        $display("[TB] multiple words and untouched word");
        applyStimulus(1'b0, 32'h44A0_0004, 32'hAAAA_0001, "wr4");
        applyStimulus(1'b0, 32'h44A0_0008, 32'hBBBB_0002, "wr8");
        applyStimulus(1'b1, 32'h44A0_0004, 32'h0, "rd4");
        applyStimulus(1'b1, 32'h44A0_0008, 32'h0, "rd8");
        applyStimulus(1'b1, 32'h44A0_000C, 32'h0, "rdC");

        $display("[TB] address aliasing");
        applyStimulus(1'b0, 32'h44A0_0040, 32'hCAFE_F00D, "wrAlias");
        applyStimulus(1'b1, 32'h44A0_0000, 32'h0, "rdAlias");

        $display("[TB] txn while busy is ignored");
        txn = 1'b1; rw = 1'b0; addr = 32'h44A0_0010; wdata = 32'h1111_2222;
        @(negedge clk);
        txn = 1'b0;
        prevBusy = busy;
        falls = 0;
        @(negedge clk);
        txn = 1'b1; rw = 1'b0; addr = 32'h44A0_0014; wdata = 32'h3333_4444;
        if (prevBusy && !busy) falls++;
        prevBusy = busy;
        @(negedge clk);
        txn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (prevBusy && !busy) falls++;
            prevBusy = busy;
            @(negedge clk);
        end
        modelMem[wordOf(32'h44A0_0010)] = 32'h1111_2222;
        checkOutput("ovl_busyFalls", 32'(falls), 32'd1);
        checkOutput("ovl_idle", 32'(busy), 32'd0);
        applyStimulus(1'b1, 32'h44A0_0010, 32'h0, "ovlRd10");
        applyStimulus(1'b1, 32'h44A0_0014, 32'h0, "ovlRd14");

        txn = 1'b1; rw = 1'b1; addr = 32'h44A0_0004; wdata = 32'h0;
        @(negedge clk);
        rw = 1'b0; addr = 32'h44A0_0018; wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        txn = 1'b0;
        waitIdle(cycles);
        lastRead = modelMem[wordOf(32'h44A0_0004)];
        checkOutput("ovl2_done", 32'(busy), 32'd0);
        checkOutput("ovl2_rdata", rdata, lastRead);
        @(negedge clk);
        applyStimulus(1'b1, 32'h44A0_0018, 32'h0, "ovl2Rd18");

        $display("[TB] reset during read address phase");
        applyStimulus(1'b0, 32'h44A0_0000, 32'h5555_AAAA, "preRstWr");
        applyStimulus(1'b1, 32'h44A0_0000, 32'h0, "preRstRd");
        txn = 1'b1; rw = 1'b1; addr = 32'h44A0_0000;
        @(negedge clk);
        txn = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midRst_busy", 32'(busy), 32'd0);
        checkOutput("midRst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("midRst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        @(negedge clk);
        applyStimulus(1'b1, 32'h44A0_0000, 32'h0, "postRstRd0");
        applyStimulus(1'b1, 32'h44A0_0004, 32'h0, "postRstRd4");

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            isRd = 1'($urandom);
            a    = {16'h44A0, 16'($urandom)};
            d    = $urandom;
            applyStimulus(isRd, a, d, "rnd");
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        for (int i = 0; i < WORDS; i++) begin
            applyStimulus(1'b1, 32'h44A0_0000 + 32'(i * 4), 32'h0, "sweep");
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
